// File: rtl/instr_miss_sched.sv
//==============================================================================
// Module      : instr_miss_sched
// Description : Arbitrates instruction-side ITLB and I-cache misses onto one
//               memory port. An ITLB miss performs a single-beat page-table
//               read at i_ptbr + 4*VPN. An I-cache miss performs a four-beat
//               line refill. TLB misses win over line misses. A flush clears
//               pending misses and drains any transaction still in flight.
// Ports       : i_clk/i_rst          - clock, async active-high reset
//               i_flush, i_ptbr      - pipeline flush, page-table base
//               i_itlb_* / o_itlb_*  - ITLB miss request and fill/fault
//               i_icache_* / o_icache_* - I-cache miss request and beat fill
//               o_mem_* / i_mem_*    - memory request/ack/data port
//               o_bus_err            - refill timeout pulse
// Config      : INSTR_MISS_TIMEOUT_EN - when defined, a wait or drain that
//               sees no i_mem_valid for 255 cycles is abandoned and o_bus_err
//               pulses; when undefined o_bus_err is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_miss_sched (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic [31:0] i_ptbr,
   input  logic        i_itlb_miss_req,
   input  logic [31:0] i_itlb_vaddr,
   output logic        o_itlb_miss_avail,
   output logic        o_itlb_fill_we,
   output logic [19:0] o_itlb_fill_ppn,
   output logic        o_itlb_page_fault,
   input  logic        i_icache_miss_req,
   input  logic [31:0] i_icache_paddr,
   output logic        o_icache_miss_avail,
   output logic        o_icache_fill_we,
   output logic [1:0]  o_icache_fill_beat,
   output logic [31:0] o_icache_fill_data,
   output logic [31:0] o_icache_fill_paddr,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic [2:0]  o_mem_beats,
   input  logic        i_mem_ack,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_data,
   output logic        o_bus_err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TLB_REQ   = 3'd1,
      S_TLB_WAIT  = 3'd2,
      S_LINE_REQ  = 3'd3,
      S_LINE_WAIT = 3'd4,
      S_DRAIN     = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_tlb_pend;
   logic [19:0] r_tlb_vpn;
   logic        r_line_pend;
   logic [27:0] r_line_tag;
   logic [1:0]  r_beat;
   logic [1:0]  w_beat_nxt;
   logic [1:0]  r_last;      // index of final beat of the transaction in flight
   logic [1:0]  w_last_nxt;
   logic        w_clr_tlb;
   logic        w_clr_line;
   logic        w_tlb_fill;
   logic        w_tlb_fault;
   logic        w_line_fill;
   logic        w_bus_err;
   logic        w_tmo_hit;
   logic        w_unused;

   // Page-offset and line-offset address bits never reach memory.
   assign w_unused = &{1'b0, i_itlb_vaddr[11:0], i_icache_paddr[3:0]};

`ifdef INSTR_MISS_TIMEOUT_EN
   logic [7:0] r_tmo;
   logic       w_waiting;

   assign w_waiting = (r_state == S_TLB_WAIT) || (r_state == S_LINE_WAIT) ||
                      (r_state == S_DRAIN);
   assign w_tmo_hit = w_waiting && !i_mem_valid && (r_tmo == 8'hFF);
   assign o_bus_err = w_bus_err;

   // Counts consecutive beat-less cycles; restarts on every beat and on
   // every state change so each wait phase gets a full window.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tmo <= 8'd0;
      end else if (!w_waiting || i_mem_valid || (w_state_nxt != r_state)) begin
         r_tmo <= 8'd0;
      end else begin
         r_tmo <= r_tmo + 8'd1;
      end
   end
`else
   logic w_unused_tmo;
   assign w_tmo_hit    = 1'b0;
   assign w_unused_tmo = w_bus_err;
   assign o_bus_err    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_last_nxt  = r_last;
      w_clr_tlb   = i_flush;
      w_clr_line  = i_flush;
      w_tlb_fill  = 1'b0;
      w_tlb_fault = 1'b0;
      w_line_fill = 1'b0;
      w_bus_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_beat_nxt = 2'd0;
            // A flush this cycle is clearing the pending flags, so do not start.
            if (r_tlb_pend && !i_flush) begin
               w_state_nxt = S_TLB_REQ;
               w_last_nxt  = 2'd0;
            end else if (r_line_pend && !i_flush) begin
               w_state_nxt = S_LINE_REQ;
               w_last_nxt  = 2'd3;
            end
         end
         S_TLB_REQ, S_LINE_REQ: begin
            if (i_flush) begin
               // Once acked the memory will still return data that must be eaten.
               w_state_nxt = i_mem_ack ? S_DRAIN : S_IDLE;
            end else if (i_mem_ack) begin
               w_state_nxt = (r_state == S_TLB_REQ) ? S_TLB_WAIT : S_LINE_WAIT;
            end
         end
         S_TLB_WAIT: begin
            if (i_mem_valid) begin
               // The single beat completes the walk even under flush.
               w_state_nxt = S_IDLE;
               w_clr_tlb   = 1'b1;
               w_tlb_fill  = !i_flush && i_mem_data[0];
               w_tlb_fault = !i_flush && !i_mem_data[0];
            end else if (i_flush) begin
               w_state_nxt = S_DRAIN;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
               w_clr_tlb   = 1'b1;
               w_tlb_fault = 1'b1;
               w_bus_err   = 1'b1;
            end
         end
         S_LINE_WAIT: begin
            if (i_mem_valid) begin
               w_line_fill = !i_flush;
               if (r_beat == 2'd3) begin
                  w_state_nxt = S_IDLE;
                  w_clr_line  = 1'b1;
               end else begin
                  w_beat_nxt = r_beat + 2'd1;
                  if (i_flush) begin
                     w_state_nxt = S_DRAIN;
                  end
               end
            end else if (i_flush) begin
               w_state_nxt = S_DRAIN;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
               w_clr_line  = 1'b1;
               w_bus_err   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (i_mem_valid) begin
               if (r_beat == r_last) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_beat_nxt = r_beat + 2'd1;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
               w_bus_err   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_beat  <= 2'd0;
         r_last  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Clearing has priority, so a pulse coincident with flush or completion
   // is dropped; a pulse while already pending is ignored.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tlb_pend  <= 1'b0;
         r_tlb_vpn   <= 20'd0;
         r_line_pend <= 1'b0;
         r_line_tag  <= 28'd0;
      end else begin
         if (w_clr_tlb) begin
            r_tlb_pend <= 1'b0;
         end else if (i_itlb_miss_req && !r_tlb_pend) begin
            r_tlb_pend <= 1'b1;
            r_tlb_vpn  <= i_itlb_vaddr[31:12];
         end
         if (w_clr_line) begin
            r_line_pend <= 1'b0;
         end else if (i_icache_miss_req && !r_line_pend) begin
            r_line_pend <= 1'b1;
            r_line_tag  <= i_icache_paddr[31:4];
         end
      end
   end

   assign o_itlb_miss_avail   = ~r_tlb_pend;
   assign o_icache_miss_avail = ~r_line_pend;

   assign o_mem_req   = (r_state == S_TLB_REQ) || (r_state == S_LINE_REQ);
   assign o_mem_addr  = (r_state == S_TLB_REQ)  ? (i_ptbr + {10'd0, r_tlb_vpn, 2'b00}) :
                        (r_state == S_LINE_REQ) ? {r_line_tag, 4'h0} : 32'd0;
   assign o_mem_beats = (r_state == S_TLB_REQ)  ? 3'd1 :
                        (r_state == S_LINE_REQ) ? 3'd4 : 3'd0;

   // Fill payloads are zeroed outside their strobe so idle outputs stay quiet.
   assign o_itlb_fill_we      = w_tlb_fill;
   assign o_itlb_fill_ppn     = w_tlb_fill ? i_mem_data[31:12] : 20'd0;
   assign o_itlb_page_fault   = w_tlb_fault;
   assign o_icache_fill_we    = w_line_fill;
   assign o_icache_fill_beat  = w_line_fill ? r_beat : 2'd0;
   assign o_icache_fill_data  = w_line_fill ? i_mem_data : 32'd0;
   assign o_icache_fill_paddr = w_line_fill ? {r_line_tag, 4'h0} : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_instr_miss_sched.sv
//==============================================================================
// Module      : tb_instr_miss_sched
// Description : Self-checking bench for instr_miss_sched. Acts as the memory
//               responder and predicts every output from the miss-handling
//               rules (TLB before line, PTE address arithmetic, beat order,
//               flush drain, timeout window).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_miss_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] ptbr = 32'd0;
   logic        itlb_req = 1'b0;
   logic [31:0] itlb_vaddr = 32'd0;
   logic        icache_req = 1'b0;
   logic [31:0] icache_paddr = 32'd0;
   logic        mem_ack = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = 32'd0;

   logic        o_itlb_miss_avail, o_itlb_fill_we, o_itlb_page_fault;
   logic [19:0] o_itlb_fill_ppn;
   logic        o_icache_miss_avail, o_icache_fill_we;
   logic [1:0]  o_icache_fill_beat;
   logic [31:0] o_icache_fill_data, o_icache_fill_paddr;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic [2:0]  o_mem_beats;
   logic        o_bus_err;

   int n_checks = 0;
   int n_errors = 0;

   instr_miss_sched dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_flush             (flush),
      .i_ptbr              (ptbr),
      .i_itlb_miss_req     (itlb_req),
      .i_itlb_vaddr        (itlb_vaddr),
      .o_itlb_miss_avail   (o_itlb_miss_avail),
      .o_itlb_fill_we      (o_itlb_fill_we),
      .o_itlb_fill_ppn     (o_itlb_fill_ppn),
      .o_itlb_page_fault   (o_itlb_page_fault),
      .i_icache_miss_req   (icache_req),
      .i_icache_paddr      (icache_paddr),
      .o_icache_miss_avail (o_icache_miss_avail),
      .o_icache_fill_we    (o_icache_fill_we),
      .o_icache_fill_beat  (o_icache_fill_beat),
      .o_icache_fill_data  (o_icache_fill_data),
      .o_icache_fill_paddr (o_icache_fill_paddr),
      .o_mem_req           (o_mem_req),
      .o_mem_addr          (o_mem_addr),
      .o_mem_beats         (o_mem_beats),
      .i_mem_ack           (mem_ack),
      .i_mem_valid         (mem_valid),
      .i_mem_data          (mem_data),
      .o_bus_err           (o_bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge with all pulse inputs low.
   task automatic next();
      @(posedge clk);
      #1;
      itlb_req   = 1'b0;
      icache_req = 1'b0;
      mem_ack    = 1'b0;
      mem_valid  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_mem_req"},     32'(o_mem_req), 32'd0);
      chk({tag, "_mem_addr"},    o_mem_addr, 32'd0);
      chk({tag, "_mem_beats"},   32'(o_mem_beats), 32'd0);
      chk({tag, "_itlb_we"},     32'(o_itlb_fill_we), 32'd0);
      chk({tag, "_itlb_ppn"},    32'(o_itlb_fill_ppn), 32'd0);
      chk({tag, "_fault"},       32'(o_itlb_page_fault), 32'd0);
      chk({tag, "_ic_we"},       32'(o_icache_fill_we), 32'd0);
      chk({tag, "_ic_beat"},     32'(o_icache_fill_beat), 32'd0);
      chk({tag, "_ic_data"},     o_icache_fill_data, 32'd0);
      chk({tag, "_ic_paddr"},    o_icache_fill_paddr, 32'd0);
      chk({tag, "_bus_err"},     32'(o_bus_err), 32'd0);
      chk({tag, "_itlb_avail"},  32'(o_itlb_miss_avail), 32'd1);
      chk({tag, "_ic_avail"},    32'(o_icache_miss_avail), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (o_mem_req !== 1'b1 && n < 20) begin
         next();
         settle();
         n++;
      end
      chk({tag, "_req_seen"}, 32'(o_mem_req), 32'd1);
   endtask

   // Page-table walk: PTE address = ptbr + 4*VPN, one beat; bit 0 = valid.
   task automatic serve_tlb(input logic [31:0] va, input logic [31:0] pt,
                            input logic [31:0] dat, input int ack_dly, input int val_dly);
      logic ok;
      wait_req("tlb");
      chk("tlb_addr", o_mem_addr, pt + ((va >> 12) << 2));
      chk("tlb_beats", 32'(o_mem_beats), 32'd1);
      repeat (ack_dly) begin
         next(); settle();
         chk("tlb_req_hold", 32'(o_mem_req), 32'd1);
      end
      mem_ack = 1'b1; settle();
      next(); settle();
      chk("tlb_req_drop", 32'(o_mem_req), 32'd0);
      chk("tlb_addr_idle", o_mem_addr, 32'd0);
      repeat (val_dly) begin
         chk("tlb_wait_quiet", 32'({o_itlb_fill_we, o_itlb_page_fault}), 32'd0);
         next(); settle();
      end
      mem_valid = 1'b1; mem_data = dat; settle();
      ok = dat[0];
      chk("tlb_fill_we", 32'(o_itlb_fill_we), 32'(ok));
      chk("tlb_fault", 32'(o_itlb_page_fault), 32'(!ok));
      if (ok) chk("tlb_ppn", 32'(o_itlb_fill_ppn), dat >> 12);
      next(); settle();
      chk("tlb_avail", 32'(o_itlb_miss_avail), 32'd1);
      chk("tlb_pulse_end", 32'({o_itlb_fill_we, o_itlb_page_fault}), 32'd0);
   endtask

   // Line refill: line-aligned address, four beats delivered in order 0..3.
   task automatic serve_line(input logic [31:0] pa, input int ack_dly, input int max_gap);
      logic [31:0] d;
      int g;
      wait_req("line");
      chk("line_addr", o_mem_addr, pa & 32'hFFFF_FFF0);
      chk("line_beats", 32'(o_mem_beats), 32'd4);
      repeat (ack_dly) begin
         next(); settle();
         chk("line_req_hold", 32'(o_mem_req), 32'd1);
      end
      mem_ack = 1'b1; settle();
      next(); settle();
      chk("line_req_drop", 32'(o_mem_req), 32'd0);
      chk("line_addr_idle", o_mem_addr, 32'd0);
      for (int b = 0; b < 4; b++) begin
         g = $urandom_range(max_gap, 0);
         repeat (g) begin
            chk("line_gap_we", 32'(o_icache_fill_we), 32'd0);
            next(); settle();
         end
         d = $urandom;
         mem_valid = 1'b1; mem_data = d; settle();
         chk("line_we", 32'(o_icache_fill_we), 32'd1);
         chk("line_beat", 32'(o_icache_fill_beat), 32'(b));
         chk("line_data", o_icache_fill_data, d);
         chk("line_paddr", o_icache_fill_paddr, pa & 32'hFFFF_FFF0);
         next(); settle();
      end
      chk("line_avail", 32'(o_icache_miss_avail), 32'd1);
      chk("line_we_end", 32'(o_icache_fill_we), 32'd0);
   endtask

   int          kind;
   int          cnt;
   logic [31:0] va, pa, dat;

   initial begin
      // ---- reset state ----
      #1 rst = 1'b1;
      #1;
      chk_reset_outs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      next(); settle();
      chk("idle_req", 32'(o_mem_req), 32'd0);

      // ---- ITLB hit-path walk, valid PTE, and minimum latency ----
      ptbr = 32'h8000_0000;
      itlb_vaddr = 32'h0040_1234; itlb_req = 1'b1; settle();
      chk("lat_n_req", 32'(o_mem_req), 32'd0);
      next(); settle();
      chk("lat_n1_req", 32'(o_mem_req), 32'd0);
      chk("lat_n1_avail", 32'(o_itlb_miss_avail), 32'd0);
      next(); settle();
      chk("lat_n2_req", 32'(o_mem_req), 32'd1);
      chk("pte_addr_fixed", o_mem_addr, 32'h8000_1004);
      serve_tlb(32'h0040_1234, 32'h8000_0000, 32'h1234_5001, 0, 0);

      // ---- ITLB walk returning invalid PTE -> page fault ----
      itlb_vaddr = 32'h0040_1234; itlb_req = 1'b1; settle();
      next(); settle();
      serve_tlb(32'h0040_1234, 32'h8000_0000, 32'h1234_5000, 1, 2);

      // ---- simultaneous misses: TLB first, repeat pulse ignored ----
      itlb_vaddr = 32'h0040_1234; itlb_req = 1'b1;
      icache_paddr = 32'h0000_2468; icache_req = 1'b1; settle();
      next();
      itlb_vaddr = 32'hFFFF_F000; itlb_req = 1'b1;
      icache_paddr = 32'h7777_7770; icache_req = 1'b1; settle();
      chk("sim_itlb_avail", 32'(o_itlb_miss_avail), 32'd0);
      chk("sim_ic_avail", 32'(o_icache_miss_avail), 32'd0);
      next(); settle();
      serve_tlb(32'h0040_1234, 32'h8000_0000, 32'h0ABC_D001, 0, 1);
      chk("sim_ic_still_pend", 32'(o_icache_miss_avail), 32'd0);
      serve_line(32'h0000_2468, 0, 0);

      // ---- flush after beat 1 of a line refill ----
      icache_paddr = 32'h0000_5A5C; icache_req = 1'b1; settle();
      next(); settle();
      wait_req("fl");
      mem_ack = 1'b1; settle();
      next(); settle();
      mem_valid = 1'b1; mem_data = 32'hAAAA_0000; settle();
      chk("fl_beat0_we", 32'(o_icache_fill_we), 32'd1);
      next();
      itlb_vaddr = 32'h1234_5678; itlb_req = 1'b1;
      mem_valid = 1'b1; mem_data = 32'hAAAA_0001; settle();
      chk("fl_beat1_we", 32'(o_icache_fill_we), 32'd1);
      chk("fl_beat1_idx", 32'(o_icache_fill_beat), 32'd1);
      next(); settle();
      chk("fl_itlb_pend", 32'(o_itlb_miss_avail), 32'd0);
      flush = 1'b1;
      icache_paddr = 32'h0BAD_0000; icache_req = 1'b1; settle();
      next(); settle();
      chk("fl_itlb_avail", 32'(o_itlb_miss_avail), 32'd1);
      chk("fl_ic_avail", 32'(o_icache_miss_avail), 32'd1);
      mem_valid = 1'b1; mem_data = 32'hAAAA_0002; settle();
      chk("fl_drain2_we", 32'(o_icache_fill_we), 32'd0);
      next();
      mem_valid = 1'b1; mem_data = 32'hAAAA_0003; settle();
      chk("fl_drain3_we", 32'(o_icache_fill_we), 32'd0);
      next(); settle();
      repeat (3) begin
         chk("fl_quiet_req", 32'(o_mem_req), 32'd0);
         next(); settle();
      end
      icache_paddr = 32'h0001_0008; icache_req = 1'b1; settle();
      next(); settle();
      serve_line(32'h0001_0008, 1, 1);

      // ---- flush in TLB_REQ without ack -> straight to idle ----
      itlb_vaddr = 32'h0000_3000; itlb_req = 1'b1; settle();
      next(); settle();
      wait_req("flreq");
      flush = 1'b1; settle();
      next(); settle();
      chk("flreq_req", 32'(o_mem_req), 32'd0);
      chk("flreq_avail", 32'(o_itlb_miss_avail), 32'd1);
      next(); settle();
      chk("flreq_req2", 32'(o_mem_req), 32'd0);
      itlb_vaddr = 32'h0000_3000; itlb_req = 1'b1; settle();
      next(); settle();
      serve_tlb(32'h0000_3000, 32'h8000_0000, 32'h5555_5001, 0, 0);

      // ---- randomized misses against the ordering/address model ----
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(3, 1);
         va   = $urandom;
         pa   = $urandom;
         dat  = $urandom;
         ptbr = $urandom & 32'hFFFF_FFFC;
         if (kind[0]) begin itlb_req = 1'b1; itlb_vaddr = va; end
         if (kind[1]) begin icache_req = 1'b1; icache_paddr = pa; end
         settle();
         next();
         itlb_vaddr = $urandom;
         icache_paddr = $urandom;
         settle();
         chk("rnd_itlb_avail", 32'(o_itlb_miss_avail), 32'(kind[0] == 0));
         chk("rnd_ic_avail", 32'(o_icache_miss_avail), 32'(kind[1] == 0));
         if (kind[0]) serve_tlb(va, ptbr, dat, $urandom_range(2, 0), $urandom_range(3, 0));
         if (kind[1]) serve_line(pa, $urandom_range(2, 0), 2);
      end

      // ---- refill timeout ----
`ifdef INSTR_MISS_TIMEOUT_EN
      icache_paddr = 32'h0000_8000; icache_req = 1'b1; settle();
      next(); settle();
      wait_req("tmo");
      mem_ack = 1'b1; settle();
      next(); settle();
      cnt = 0;
      for (int k = 0; k < 255; k++) begin
         if (o_bus_err !== 1'b0) cnt++;
         next(); settle();
      end
      chk("tmo_early", 32'(cnt), 32'd0);
      chk("tmo_bus_err", 32'(o_bus_err), 32'd1);
      next(); settle();
      chk("tmo_err_end", 32'(o_bus_err), 32'd0);
      chk("tmo_ic_avail", 32'(o_icache_miss_avail), 32'd1);
      chk("tmo_req", 32'(o_mem_req), 32'd0);
      itlb_vaddr = 32'h0000_9000; itlb_req = 1'b1; settle();
      next(); settle();
      wait_req("tmot");
      mem_ack = 1'b1; settle();
      next(); settle();
      repeat (255) begin
         next(); settle();
      end
      chk("tmot_bus_err", 32'(o_bus_err), 32'd1);
      chk("tmot_fault", 32'(o_itlb_page_fault), 32'd1);
      next(); settle();
      chk("tmot_avail", 32'(o_itlb_miss_avail), 32'd1);
`else
      icache_paddr = 32'h0000_8000; icache_req = 1'b1; settle();
      next(); settle();
      wait_req("ntmo");
      mem_ack = 1'b1; settle();
      next(); settle();
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
         if (o_bus_err !== 1'b0) cnt++;
         next(); settle();
      end
      chk("ntmo_no_err", 32'(cnt), 32'd0);
      chk("ntmo_still_wait", 32'(o_icache_miss_avail), 32'd0);
      for (int b = 0; b < 4; b++) begin
         mem_valid = 1'b1; mem_data = 32'(b); settle();
         chk("ntmo_late_beat", 32'(o_icache_fill_beat), 32'(b));
         next(); settle();
      end
      chk("ntmo_done", 32'(o_icache_miss_avail), 32'd1);
`endif

      // ---- reset asserted in LINE_WAIT ----
      icache_paddr = 32'h0000_C0C0; icache_req = 1'b1; settle();
      next(); settle();
      wait_req("rstw");
      mem_ack = 1'b1; settle();
      next(); settle();
      mem_valid = 1'b1; mem_data = 32'h1111_1111; settle();
      chk("rstw_beat0", 32'(o_icache_fill_we), 32'd1);
      next();
      mem_valid = 1'b1; mem_data = 32'h2222_2222;
      rst = 1'b1; settle();
      chk_reset_outs("rstw");
      @(posedge clk);
      #1 rst = 1'b0;
      next(); settle();
      chk("rstw_after_req", 32'(o_mem_req), 32'd0);
      chk("rstw_after_avail", 32'(o_icache_miss_avail), 32'd1);
      icache_paddr = 32'h0000_D0D4; icache_req = 1'b1; settle();
      next(); settle();
      serve_line(32'h0000_D0D4, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_miss_sched.md
INSTR_MISS_SCHED -- requirements
Module: instr_miss_sched

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: i_rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: i_flush  in  1  pipeline flush; i_ptbr  in  32  page-table base (word aligned).
REQ-004 SHALL have: i_itlb_miss_req  in  1  one-cycle pulse; i_itlb_vaddr  in  32  faulting PC.
REQ-005 SHALL have: o_itlb_miss_avail  out  1; o_itlb_fill_we  out  1; o_itlb_fill_ppn  out  20; o_itlb_page_fault  out  1.
REQ-006 SHALL have: i_icache_miss_req  in  1  one-cycle pulse; i_icache_paddr  in  32  miss address.
REQ-007 SHALL have: o_icache_miss_avail  out  1; o_icache_fill_we  out  1; o_icache_fill_beat  out  2; o_icache_fill_data  out  32; o_icache_fill_paddr  out  32 (line aligned).
REQ-008 SHALL have memory port: o_mem_req  out  1; o_mem_addr  out  32; o_mem_beats  out  3 (1 or 4); i_mem_ack  in  1; i_mem_valid  in  1; i_mem_data  in  32.
REQ-009 SHALL have: o_bus_err  out  1  one-cycle pulse on refill timeout.

Function
REQ-010 SHALL implement states IDLE, TLB_REQ, TLB_WAIT, LINE_REQ, LINE_WAIT, DRAIN.
REQ-011 SHALL latch each miss pulse into a pending flag plus address register; a second pulse of the same kind while pending SHALL be ignored.
REQ-012 SHALL, from IDLE, enter TLB_REQ if TLB pending, else LINE_REQ if line pending; TLB wins on simultaneous pending.
REQ-013 SHALL, in TLB_REQ, assert o_mem_req with o_mem_addr = i_ptbr + {vaddr[31:12],2'b00} (32-bit wrap), o_mem_beats = 1; hold until i_mem_ack, then enter TLB_WAIT.
REQ-014 SHALL, on i_mem_valid in TLB_WAIT, pulse o_itlb_fill_we for one cycle with ppn = data[31:12] if data[0]=1, else pulse o_itlb_page_fault (fill_we low); clear TLB pending; return to IDLE.
REQ-015 SHALL, in LINE_REQ, assert o_mem_req, o_mem_addr = {paddr[31:4],4'h0}, o_mem_beats = 4; on i_mem_ack enter LINE_WAIT.
REQ-016 SHALL, in LINE_WAIT, pulse o_icache_fill_we once per i_mem_valid with beat counter 0..3; after beat 3 clear line pending and return to IDLE.
REQ-017 SHALL drive o_itlb_miss_avail = ~TLB pending and o_icache_miss_avail = ~line pending, combinationally from registers.
REQ-018 SHALL deassert o_mem_req in all states except TLB_REQ/LINE_REQ; o_mem_addr SHALL be 0 when o_mem_req is low.
REQ-019 SHALL, on i_flush, clear both pending flags; in a *_REQ state, move to IDLE if i_mem_ack is low that cycle, else to DRAIN; in a *_WAIT state, move to DRAIN.
REQ-020 SHALL, in DRAIN, consume remaining i_mem_valid beats of the in-flight transaction with all fill/fault outputs suppressed, then go to IDLE.
REQ-021 SHALL accept a miss pulse coincident with i_flush as not latched.
REQ-022 SHALL give minimum latency: pulse at cycle N -> o_mem_req high at N+2 (latch N+1, state N+2).

Reset
REQ-023 SHALL, while i_rst high, asynchronously force state IDLE, pending flags 0, beat counter 0, all outputs 0 except o_itlb_miss_avail = o_icache_miss_avail = 1.
REQ-024 SHALL, on reset assertion mid-transaction, abandon it without draining.

Configuration
REQ-025 SHALL support macro INSTR_MISS_TIMEOUT_EN.
REQ-026 SHALL, with it defined, count cycles in TLB_WAIT/LINE_WAIT/DRAIN without i_mem_valid in an 8-bit counter (cleared on each i_mem_valid or state change); on reaching 255 pulse o_bus_err, raise o_itlb_page_fault if in TLB_WAIT, clear the active pending flag, go to IDLE.
REQ-027 SHALL, without it, omit the counter; o_bus_err SHALL be tied 0 and WAIT states never time out.

Verification
REQ-028 SHALL cover: ITLB pulse, vaddr=0x0040_1234, ptbr=0x8000_0000, ack next cycle, data=0x1234_5001 -> mem_addr=0x8000_1004, beats=1; fill_we pulse with ppn=0x12345.
REQ-029 SHALL cover: same but data=0x1234_5000 -> o_itlb_page_fault pulse, no fill_we, itlb_avail returns 1.
REQ-030 SHALL cover: simultaneous ITLB and ICache pulses, paddr=0x0000_2468 -> TLB walk first, then mem_addr=0x0000_2460, beats=4, four fill_we pulses beat 0..3.
REQ-031 SHALL cover: i_flush after beat 1 of a line refill -> beats 2,3 drained with fill_we low; both avail=1; next request served normally.
REQ-032 SHALL cover: INSTR_MISS_TIMEOUT_EN defined, no i_mem_valid after ack -> o_bus_err pulse 255 cycles after WAIT entry, state IDLE.
REQ-033 SHALL cover: i_rst asserted in LINE_WAIT -> same-cycle outputs at reset values, state IDLE.
